// File: rtl/wb_regfile.sv
// MEM/WB consumer: selects the writeback value, commits it into a 32-entry
// register file and serves two ID-stage read ports with optional same-cycle bypass.

module wb_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic                               wb_vld,
  input  logic [ADDR_W-1:0]                  wb_addr,
  input  logic [DATA_W-1:0]                  wb_data,
  output logic [DATA_W-1:0]                  rdata
);
  logic hit;

  // wb_vld already excludes r0, so a bypass can never leak a value into r0
  assign hit = BYPASS && wb_vld && (raddr == wb_addr);

  always_comb begin
    rdata = regs[raddr];
    if (raddr == '0)  rdata = '0;
    else if (hit)     rdata = wb_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDData_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] WBData_o,
  output logic [ADDR_W-1:0] WBaddr_o,
  output logic              WBValid_o,
  output logic [CNT_W-1:0]  WrCount_o
);
  localparam int NREG  = 1 << ADDR_W;
  localparam int NPORT = 2;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t                           wb;
  logic [NREG-1:0][DATA_W-1:0]       regs;
  logic [CNT_W-1:0]                  wr_cnt;
  logic [NPORT-1:0][ADDR_W-1:0]      rd_addr;
  logic [NPORT-1:0][DATA_W-1:0]      rd_data;

  assign wb.data = MemToReg_i ? RDData_i : ALUResult_i;
  assign wb.addr = RDaddr_i;
  assign wb.vld  = RegWrite_i && (RDaddr_i != '0);

  assign WBData_o  = wb.data;
  assign WBaddr_o  = wb.addr;
  assign WBValid_o = wb.vld;
  assign WrCount_o = wr_cnt;

  // Reset wins over a coincident commit: the write is lost and not counted
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs   <= '0;
      wr_cnt <= '0;
    end else if (wb.vld) begin
      regs[wb.addr] <= wb.data;
      if (wr_cnt != {CNT_W{1'b1}}) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign rd_addr[0] = RSaddr_i;
  assign rd_addr[1] = RTaddr_i;

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    wb_regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .raddr   (rd_addr[p]),
      .regs    (regs),
      .wb_vld  (wb.vld),
      .wb_addr (wb.addr),
      .wb_data (wb.data),
      .rdata   (rd_data[p])
    );
  end

  assign RSdata_o = rd_data[0];
  assign RTdata_o = rd_data[1];
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: three instances (bypass, no bypass, 2-bit counter)
// driven in lockstep and compared against a plain array/counter model.

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rw = 1'b0, m2r = 1'b0;
  logic [4:0]  rd = '0, rs = '0, rt = '0;
  logic [31:0] rdd = '0, alu = '0;

  logic [31:0] rs0, rt0, wbd0, rs1, rt1, wbd1, rs2, rt2, wbd2;
  logic [4:0]  wba0, wba1, wba2;
  logic        wbv0, wbv1, wbv2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks = 0, errors = 0;

  // reference model
  logic [31:0] mem [32];
  int          mcnt;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1'b1), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(rw), .MemToReg_i(m2r), .RDaddr_i(rd),
    .RDData_i(rdd), .ALUResult_i(alu), .RSaddr_i(rs), .RTaddr_i(rt),
    .RSdata_o(rs0), .RTdata_o(rt0), .WBData_o(wbd0), .WBaddr_o(wba0),
    .WBValid_o(wbv0), .WrCount_o(cnt0));
  wb_regfile #(.BYPASS(1'b0), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(rw), .MemToReg_i(m2r), .RDaddr_i(rd),
    .RDData_i(rdd), .ALUResult_i(alu), .RSaddr_i(rs), .RTaddr_i(rt),
    .RSdata_o(rs1), .RTdata_o(rt1), .WBData_o(wbd1), .WBaddr_o(wba1),
    .WBValid_o(wbv1), .WrCount_o(cnt1));
  wb_regfile #(.BYPASS(1'b1), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .RegWrite_i(rw), .MemToReg_i(m2r), .RDaddr_i(rd),
    .RDData_i(rdd), .ALUResult_i(alu), .RSaddr_i(rs), .RTaddr_i(rt),
    .RSdata_o(rs2), .RTdata_o(rt2), .WBData_o(wbd2), .WBaddr_o(wba2),
    .WBValid_o(wbv2), .WrCount_o(cnt2));

  function automatic logic [31:0] exp_wb();
    return m2r ? rdd : alu;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && rw && rd != 0 && rd == a) return exp_wb();
    return mem[a];
  endfunction

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  task automatic drive(input logic r, input logic w, input logic m, input logic [4:0] d,
                       input logic [31:0] dd, input logic [31:0] a,
                       input logic [4:0] s, input logic [4:0] t);
    rst = r; rw = w; m2r = m; rd = d; rdd = dd; alu = a; rs = s; rt = t;
    #1;
  endtask

  // advance one clock and apply the architectural effect to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (mem[i]) mem[i] = 32'h0;
      mcnt = 0;
    end else if (rw && rd != 0) begin
      mem[rd] = exp_wb();
      mcnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, a[4:0], 5'(31 - a));
      checks++;
      if (rs0 !== 0 || rt0 !== 0 || rs1 !== 0 || rt1 !== 0) begin
        errors++;
        $display("FAIL reset_read a=%0d: rs0=%h rt0=%h rs1=%h rt1=%h required 0", a, rs0, rt0, rs1, rt1);
      end
    end
    checks++;
    if (cnt0 !== 0 || cnt1 !== 0 || cnt2 !== 0) begin
      errors++;
      $display("FAIL reset_cnt: %0d %0d %0d required 0", cnt0, cnt1, cnt2);
    end
  endtask

  task automatic test_bypass_alu();
    drive(0, 1, 0, 5, 32'h0BAD_0BAD, 32'h1234_5678, 5, 0);
    checks++;
    if (rs0 !== 32'h1234_5678 || wbv0 !== 1'b1 || wba0 !== 5) begin
      errors++;
      $display("FAIL bypass_alu: rs=%h v=%b a=%0d required 12345678 1 5", rs0, wbv0, wba0);
    end
    checks++;
    if (rs1 !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_alu: rs=%h required 0", rs1);
    end
    tick();
    drive(0, 0, 0, 5, 0, 0, 5, 5);
    checks++;
    if (rs0 !== 32'h1234_5678 || rt1 !== 32'h1234_5678 || cnt0 !== 1) begin
      errors++;
      $display("FAIL stored_alu: rs0=%h rt1=%h cnt=%0d required 12345678 12345678 1", rs0, rt1, cnt0);
    end
  endtask

  task automatic test_memtoreg();
    drive(0, 1, 1, 7, 32'hDEAD_BEEF, 32'h1, 7, 7);
    checks++;
    if (rs0 !== 32'hDEAD_BEEF || rt0 !== 32'hDEAD_BEEF || wbd0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL memtoreg_bypass: rs=%h rt=%h wb=%h required deadbeef", rs0, rt0, wbd0);
    end
    checks++;
    if (rs1 !== 32'h0 || rt1 !== 32'h0 || wbd1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL memtoreg_nobypass: rs=%h rt=%h wb=%h required 0 0 deadbeef", rs1, rt1, wbd1);
    end
    tick();
    drive(0, 0, 1, 7, 32'h0, 32'h0, 7, 7);
    checks++;
    if (rs1 !== 32'hDEAD_BEEF || rt1 !== 32'hDEAD_BEEF || cnt1 !== 2) begin
      errors++;
      $display("FAIL memtoreg_after: rs=%h rt=%h cnt=%0d required deadbeef deadbeef 2", rs1, rt1, cnt1);
    end
  endtask

  task automatic test_r0();
    drive(0, 1, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, 0);
    checks++;
    if (wbv0 !== 1'b0 || rs0 !== 0 || rt0 !== 0 || wbd0 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL r0_write: v=%b rs=%h rt=%h wb=%h required 0 0 0 ffffffff", wbv0, rs0, rt0, wbd0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (rs0 !== 0 || rs1 !== 0 || cnt0 !== 2) begin
      errors++;
      $display("FAIL r0_after: rs0=%h rs1=%h cnt=%0d required 0 0 2", rs0, rs1, cnt0);
    end
  endtask

  task automatic test_reset_collision();
    drive(0, 1, 0, 3, 0, 32'hA5, 3, 4);
    tick();
    drive(1, 1, 0, 4, 0, 32'h5A, 4, 3);
    checks++;
    if (rs0 !== 32'h5A || rt0 !== 32'hA5) begin
      errors++;
      $display("FAIL reset_bypass: rs=%h rt=%h required 5a a5", rs0, rt0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 3, 4);
    checks++;
    if (rs0 !== 0 || rt0 !== 0 || cnt0 !== 0 || cnt1 !== 0) begin
      errors++;
      $display("FAIL reset_collide: r3=%h r4=%h cnt=%0d/%0d required 0", rs0, rt0, cnt0, cnt1);
    end
    drive(0, 1, 0, 4, 0, 32'h5A, 4, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    checks++;
    if (cnt0 !== 1 || rs0 !== 32'h5A) begin
      errors++;
      $display("FAIL post_reset_write: cnt=%0d r4=%h required 1 5a", cnt0, rs0);
    end
  endtask

  task automatic test_saturation();
    int seq [5] = '{1, 2, 3, 3, 3};
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 5'(i + 1), 0, $urandom, 0, 0);
      tick();
      checks++;
      if (cnt2 !== seq[i][1:0] || cnt0 !== 16'(i + 1)) begin
        errors++;
        $display("FAIL saturate i=%0d: cnt2=%0d cnt16=%0d required %0d %0d", i, cnt2, cnt0, seq[i], i + 1);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] d;
    for (int n = 0; n < 400; n++) begin
      d = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            d, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom));
      checks++;
      if (rs0 !== exp_rd(rs, 1) || rt0 !== exp_rd(rt, 1) || rs2 !== exp_rd(rs, 1) || rt2 !== exp_rd(rt, 1)) begin
        errors++;
        $display("FAIL rand_bypass n=%0d: rs=%h rt=%h required %h %h", n, rs0, rt0, exp_rd(rs, 1), exp_rd(rt, 1));
      end
      checks++;
      if (rs1 !== exp_rd(rs, 0) || rt1 !== exp_rd(rt, 0)) begin
        errors++;
        $display("FAIL rand_nobypass n=%0d: rs=%h rt=%h required %h %h", n, rs1, rt1, exp_rd(rs, 0), exp_rd(rt, 0));
      end
      checks++;
      if (wbd0 !== exp_wb() || wba1 !== rd || wbv2 !== (rw && rd != 0)) begin
        errors++;
        $display("FAIL rand_wb n=%0d: d=%h a=%0d v=%b required %h %0d %b", n, wbd0, wba1, wbv2, exp_wb(), rd, (rw && rd != 0));
      end
      tick();
      checks++;
      if (cnt0 !== 16'(sat(mcnt, 16)) || cnt1 !== 16'(sat(mcnt, 16)) || cnt2 !== 2'(sat(mcnt, 2))) begin
        errors++;
        $display("FAIL rand_cnt n=%0d: %0d %0d %0d required %0d %0d", n, cnt0, cnt1, cnt2, sat(mcnt, 16), sat(mcnt, 2));
      end
    end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mcnt = 0;
    @(negedge clk);
    test_reset();
    test_bypass_alu();
    test_memtoreg();
    test_r0();
    test_reset_collision();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
